exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- MEM-stage exception detector and prioritizer; the producer side of the CP0 exception interface.
- Each cycle it collects per-instruction exception flags plus the pending-interrupt condition, picks the single highest-priority cause, and drives the excepttype/PC/delay-slot/bad-address bundle that CP0 consumes on the same edge.
- It then sequences a pipeline flush and a PC redirect, to the handler vector or to EPC for eret, and holds the redirect until the sram-like fetch port accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, handler entry address.
- NONE_CODE, 32'hFFFF_FFFF, excepttype value meaning "no exception" (CP0 ignores it).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_valid_i  in  1  a real instruction occupies MEM.
- mem_stall_i  in  1  MEM stalled by the data bus; the instruction does not commit this cycle.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- mem_addr_i  in  32  load/store effective address.
- f_adel_if_i, f_ri_i, f_ov_i, f_trap_i, f_syscall_i, f_break_i, f_adel_ld_i, f_ades_i, f_eret_i  in  1 each  per-instruction flags.
- cp0_status_i  in  32  current Status.
- cp0_cause_i  in  32  current Cause.
- cp0_epc_i  in  32  current EPC.
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable.
- wb_cp0_waddr_i  in  5  WB-stage mtc0 register address.
- wb_cp0_wdata_i  in  32  WB-stage mtc0 write data.
- fetch_ack_i  in  1  fetch port accepted the redirect PC.
- excepttype_o  out  32  to CP0.
- exc_pc_o  out  32  to CP0 current_inst_addr.
- exc_in_delayslot_o  out  1  to CP0.
- bad_addr_o  out  32  to CP0.
- flush_o  out  1  flush IF..MEM.
- redirect_valid_o  out  1  newpc_o is valid.
- newpc_o  out  32  redirect target.

Behaviour:
- Commit condition: state==IDLE && mem_valid_i && !mem_stall_i && !rst.
- Interrupt pending: |(cp0_cause_i[15:8] & cp0_status_i[15:8]) && cp0_status_i[0] && !cp0_status_i[1].
- Priority, highest first:
  - interrupt 32'h0
  - f_adel_if 32'h4
  - f_ri 32'hA
  - f_ov 32'hC
  - f_trap 32'hD
  - f_syscall 32'h8
  - f_break 32'h9
  - f_adel_ld 32'h4
  - f_ades 32'h5
  - f_eret 32'hE
- excepttype_o is combinational, zero latency, so CP0 captures it on the commit edge. Its value is the chosen code when committing, otherwise NONE_CODE.
- exc_pc_o = mem_pc_i and exc_in_delayslot_o = mem_in_delayslot_i, always passed through.
- bad_addr_o: mem_pc_i for fetch AdEL, otherwise mem_addr_i. Don't-care when excepttype_o is not 4 or 5.
- FSM states and transitions:
  - IDLE: on a commit with code != NONE_CODE, latch the target into newpc_o and go to FLUSH. Target is EXC_VECTOR, or the EPC source for eret.
  - FLUSH: flush_o=1 and redirect_valid_o=1 for exactly one cycle. Go to IDLE if fetch_ack_i, else to REDIRECT.
  - REDIRECT: flush_o=0, redirect_valid_o=1, newpc_o held stable. Go to IDLE on fetch_ack_i.
- In FLUSH and REDIRECT, excepttype_o=NONE_CODE regardless of inputs; flagged instructions arriving then are discarded.
- Stalled instruction (mem_stall_i=1): no exception reported. The flags are re-evaluated when the stall drops; an interrupt arriving during the stall is taken at commit.
- Reset values: state=IDLE, flush_o=0, redirect_valid_o=0, newpc_o=0. Under rst, excepttype_o=NONE_CODE.
- Reset mid-FLUSH/REDIRECT aborts to IDLE immediately.
- Interrupt with another flag set in the same cycle: the interrupt wins; EPC is the interrupted instruction (CP0 applies -4 for delay-slot instructions).

Optional Feature:
- Macro: EXC_EPC_BYPASS_EN.
- Defined: for eret, if wb_cp0_we_i && wb_cp0_waddr_i==14 in the same cycle, the target is wb_cp0_wdata_i, otherwise cp0_epc_i.
- Undefined: the target is always cp0_epc_i and the wb_cp0_* inputs are ignored.

Test Plan:
- Syscall at pc=0xBFC0_1000, no delay slot, fetch_ack_i tied 1 -> excepttype_o=8 on the commit cycle; next cycle flush_o=1, newpc_o=0xBFC0_0380; following cycle all deasserted.
- Status=0x0000_0401, Cause[10]=1, f_ov_i=1 -> excepttype_o=0 (interrupt beats Ov).
- Same setup but Status=0x0000_0403 (EXL set) -> excepttype_o=0xC.
- Store at mem_addr_i=0x8000_0002 with f_ades_i=1 and mem_stall_i=1 for 3 cycles -> NONE_CODE while stalled; on release excepttype_o=5 and bad_addr_o=0x8000_0002.
- eret with cp0_epc_i=0xBFC0_2000 and fetch_ack_i low 4 cycles -> flush_o one cycle; redirect_valid_o=1 with newpc_o=0xBFC0_2000 for 5 cycles; FSM IDLE after the ack. A flagged instruction during REDIRECT is ignored.
- With EXC_EPC_BYPASS_EN: eret while WB writes EPC=0xBFC0_3000 (cp0_epc_i=0xBFC0_2000) -> newpc_o=0xBFC0_3000. Without the macro -> 0xBFC0_2000.
- rst pulsed in FLUSH -> next cycle flush_o=0, redirect_valid_o=0, newpc_o=0.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// CP0 exception bundle plus the flush/redirect handshake to the fetch port.
// master = exc_ctrl (producer), slave = CP0 / fetch side.
interface exc_ctrl_if;
    logic [31:0] excepttype;
    logic [31:0] exc_pc;
    logic        exc_in_delayslot;
    logic [31:0] bad_addr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] newpc;
    logic        fetch_ack;

    modport master (
        output excepttype, exc_pc, exc_in_delayslot, bad_addr,
        output flush, redirect_valid, newpc,
        input  fetch_ack
    );

    modport slave (
        input  excepttype, exc_pc, exc_in_delayslot, bad_addr,
        input  flush, redirect_valid, newpc,
        output fetch_ack
    );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception prioritizer and flush/redirect sequencer feeding CP0.
// Optional macro EXC_EPC_BYPASS_EN: eret target forwards a same-cycle WB mtc0 write to EPC.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] NONE_CODE  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        f_adel_if_i,
    input  logic        f_ri_i,
    input  logic        f_ov_i,
    input  logic        f_trap_i,
    input  logic        f_syscall_i,
    input  logic        f_break_i,
    input  logic        f_adel_ld_i,
    input  logic        f_ades_i,
    input  logic        f_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    exc_ctrl_if.master  exc
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic [31:0] newpc_q, newpc_d;

    logic        int_pending;
    logic        commit;
    logic        take;
    logic [31:0] code;
    logic [31:0] epc_src;
    logic [31:0] target;

    assign int_pending = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
                         && cp0_status_i[0] && !cp0_status_i[1];
    assign commit = (state_q == IDLE) && mem_valid_i && !mem_stall_i && !rst;

    always_comb begin
        code = NONE_CODE;
        if      (int_pending) code = 32'h0;
        else if (f_adel_if_i) code = 32'h4;
        else if (f_ri_i)      code = 32'hA;
        else if (f_ov_i)      code = 32'hC;
        else if (f_trap_i)    code = 32'hD;
        else if (f_syscall_i) code = 32'h8;
        else if (f_break_i)   code = 32'h9;
        else if (f_adel_ld_i) code = 32'h4;
        else if (f_ades_i)    code = 32'h5;
        else if (f_eret_i)    code = 32'hE;
    end

`ifdef EXC_EPC_BYPASS_EN
    // An mtc0 to EPC retiring in WB this cycle is newer than cp0_epc_i.
    assign epc_src = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;
    logic unused_ok;
    assign unused_ok = &{1'b0, cp0_status_i[31:16], cp0_status_i[7:2],
                         cp0_cause_i[31:16], cp0_cause_i[7:0]};
`else
    assign epc_src = cp0_epc_i;
    logic unused_ok;
    assign unused_ok = &{1'b0, cp0_status_i[31:16], cp0_status_i[7:2],
                         cp0_cause_i[31:16], cp0_cause_i[7:0],
                         wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i};
`endif

    assign take   = commit && (code != NONE_CODE);
    assign target = (code == 32'hE) ? epc_src : EXC_VECTOR;

    assign exc.excepttype       = commit ? code : NONE_CODE;
    assign exc.exc_pc           = mem_pc_i;
    assign exc.exc_in_delayslot = mem_in_delayslot_i;
    assign exc.bad_addr         = (!int_pending && f_adel_if_i) ? mem_pc_i : mem_addr_i;
    assign exc.flush            = flush_q;
    assign exc.redirect_valid   = redir_q;
    assign exc.newpc            = newpc_q;

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        redir_d = redir_q;
        newpc_d = newpc_q;
        case (state_q)
            IDLE: begin
                redir_d = 1'b0;
                if (take) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                    redir_d = 1'b1;
                    newpc_d = target;
                end
            end
            FLUSH: begin
                state_d = exc.fetch_ack ? IDLE : REDIRECT;
                redir_d = !exc.fetch_ack;
            end
            REDIRECT: begin
                if (exc.fetch_ack) begin
                    state_d = IDLE;
                    redir_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                redir_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            newpc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            newpc_q <= newpc_d;
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Scenario bench for exc_ctrl: expected excepttype values queued at drive time, popped at sample time.
module tb_exc_ctrl;
    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_stall_i, mem_in_delayslot_i;
    logic [31:0] mem_pc_i, mem_addr_i;
    logic        f_adel_if_i, f_ri_i, f_ov_i, f_trap_i, f_syscall_i;
    logic        f_break_i, f_adel_ld_i, f_ades_i, f_eret_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;

    exc_ctrl_if bus ();

    exc_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i),
        .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_addr_i(mem_addr_i),
        .f_adel_if_i(f_adel_if_i), .f_ri_i(f_ri_i), .f_ov_i(f_ov_i),
        .f_trap_i(f_trap_i), .f_syscall_i(f_syscall_i), .f_break_i(f_break_i),
        .f_adel_ld_i(f_adel_ld_i), .f_ades_i(f_ades_i), .f_eret_i(f_eret_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_wdata_i(wb_cp0_wdata_i),
        .exc(bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    task automatic clear_inputs();
        mem_valid_i = 0; mem_stall_i = 0; mem_in_delayslot_i = 0;
        mem_pc_i = 32'h0; mem_addr_i = 32'h0;
        f_adel_if_i = 0; f_ri_i = 0; f_ov_i = 0; f_trap_i = 0; f_syscall_i = 0;
        f_break_i = 0; f_adel_ld_i = 0; f_ades_i = 0; f_eret_i = 0;
        cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 5'd0; wb_cp0_wdata_i = 32'h0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.fetch_ack = 1'b1;
        rst = 1'b1;
        mem_valid_i = 1; f_syscall_i = 1;
        step(); step();
        exp_q.push_back(NONE);
        @(negedge clk);
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp) begin n_bad++; $display("FAIL rst_exctype got %h exp %h", bus.excepttype, exp); end
        n_cmp++;
        if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.newpc !== 32'h0) begin
            n_bad++; $display("FAIL rst_regs got f=%b r=%b pc=%h exp 0 0 0", bus.flush, bus.redirect_valid, bus.newpc);
        end
        clear_inputs();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_syscall();
        bus.fetch_ack = 1'b1;
        mem_valid_i = 1; mem_pc_i = 32'hBFC0_1000; f_syscall_i = 1;
        exp_q.push_back(32'h8);
        @(negedge clk);
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp) begin n_bad++; $display("FAIL sys_exctype got %h exp %h", bus.excepttype, exp); end
        n_cmp++;
        if (bus.exc_pc !== 32'hBFC0_1000 || bus.exc_in_delayslot !== 1'b0) begin
            n_bad++; $display("FAIL sys_pc got %h/%b exp bfc01000/0", bus.exc_pc, bus.exc_in_delayslot);
        end
        step(); clear_inputs();
        exp_q.push_back(NONE);
        @(negedge clk);
        n_cmp++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.newpc !== VEC) begin
            n_bad++; $display("FAIL sys_flush got f=%b r=%b pc=%h exp 1 1 %h", bus.flush, bus.redirect_valid, bus.newpc, VEC);
        end
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp) begin n_bad++; $display("FAIL sys_flush_exctype got %h exp %h", bus.excepttype, exp); end
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_bad++; $display("FAIL sys_done got f=%b r=%b exp 0 0", bus.flush, bus.redirect_valid);
        end
        step();
    endtask

    task automatic test_interrupt();
        logic [31:0] st [2];
        logic [31:0] ex [2];
        st[0] = 32'h0000_0401; ex[0] = 32'h0;
        st[1] = 32'h0000_0403; ex[1] = 32'hC;
        bus.fetch_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            mem_valid_i = 1; mem_pc_i = 32'h8000_1234 + 32'(i); mem_in_delayslot_i = 1;
            cp0_status_i = st[i]; cp0_cause_i = 32'h0000_0400; f_ov_i = 1;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            exp = exp_q.pop_front(); n_cmp++;
            if (bus.excepttype !== exp) begin n_bad++; $display("FAIL int_exctype[%0d] got %h exp %h", i, bus.excepttype, exp); end
            n_cmp++;
            if (bus.exc_in_delayslot !== 1'b1) begin n_bad++; $display("FAIL int_ds[%0d] got %b exp 1", i, bus.exc_in_delayslot); end
            step(); clear_inputs(); step(); step();
        end
    endtask

    task automatic test_stall_ades();
        bus.fetch_ack = 1'b1;
        clear_inputs();
        mem_valid_i = 1; mem_pc_i = 32'hBFC0_1100; mem_addr_i = 32'h8000_0002;
        f_ades_i = 1; mem_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(NONE);
            @(negedge clk);
            exp = exp_q.pop_front(); n_cmp++;
            if (bus.excepttype !== exp || bus.flush !== 1'b0) begin
                n_bad++; $display("FAIL stall_exctype[%0d] got %h f=%b exp %h f=0", i, bus.excepttype, bus.flush, exp);
            end
            step();
        end
        mem_stall_i = 0;
        exp_q.push_back(32'h5);
        @(negedge clk);
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp) begin n_bad++; $display("FAIL ades_exctype got %h exp %h", bus.excepttype, exp); end
        n_cmp++;
        if (bus.bad_addr !== 32'h8000_0002) begin n_bad++; $display("FAIL ades_badaddr got %h exp 80000002", bus.bad_addr); end
        step(); clear_inputs(); step(); step();
        // fetch AdEL outranks RI and reports the PC as the bad address
        mem_valid_i = 1; mem_pc_i = 32'hBFC0_0FFD; mem_addr_i = 32'h1234_5678;
        f_adel_if_i = 1; f_ri_i = 1;
        exp_q.push_back(32'h4);
        @(negedge clk);
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp || bus.bad_addr !== 32'hBFC0_0FFD) begin
            n_bad++; $display("FAIL adelif got %h/%h exp %h/bfc00ffd", bus.excepttype, bus.bad_addr, exp);
        end
        step(); clear_inputs(); step(); step();
    endtask

    task automatic test_eret_backpressure();
        clear_inputs();
        bus.fetch_ack = 1'b0;
        mem_valid_i = 1; mem_pc_i = 32'hBFC0_1200; f_eret_i = 1; cp0_epc_i = 32'hBFC0_2000;
        exp_q.push_back(32'hE);
        @(negedge clk);
        exp = exp_q.pop_front(); n_cmp++;
        if (bus.excepttype !== exp) begin n_bad++; $display("FAIL eret_exctype got %h exp %h", bus.excepttype, exp); end
        step(); clear_inputs();
        for (int i = 0; i < 5; i++) begin
            if (i >= 1) begin mem_valid_i = 1; f_syscall_i = 1; end
            bus.fetch_ack = (i == 4);
            exp_q.push_back(NONE);
            @(negedge clk);
            n_cmp++;
            if (bus.redirect_valid !== 1'b1 || bus.newpc !== 32'hBFC0_2000 || bus.flush !== (i == 0)) begin
                n_bad++; $display("FAIL eret_redir[%0d] got r=%b pc=%h f=%b exp 1 bfc02000 %b",
                                  i, bus.redirect_valid, bus.newpc, bus.flush, (i == 0));
            end
            exp = exp_q.pop_front(); n_cmp++;
            if (bus.excepttype !== exp) begin n_bad++; $display("FAIL eret_discard[%0d] got %h exp %h", i, bus.excepttype, exp); end
            step();
        end
        clear_inputs();
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
            n_bad++; $display("FAIL eret_idle got r=%b f=%b exp 0 0", bus.redirect_valid, bus.flush);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL eret_noflush got %b exp 0", bus.flush); end
        step();
    endtask

    task automatic test_epc_bypass();
        logic [4:0]  wa [2];
        logic [31:0] tgt [2];
        wa[0] = 5'd14;
`ifdef EXC_EPC_BYPASS_EN
        tgt[0] = 32'hBFC0_3000;
`else
        tgt[0] = 32'hBFC0_2000;
`endif
        wa[1] = 5'd13; tgt[1] = 32'hBFC0_2000;
        bus.fetch_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            mem_valid_i = 1; f_eret_i = 1; cp0_epc_i = 32'hBFC0_2000;
            wb_cp0_we_i = 1; wb_cp0_waddr_i = wa[i]; wb_cp0_wdata_i = 32'hBFC0_3000;
            step(); clear_inputs();
            @(negedge clk);
            n_cmp++;
            if (bus.newpc !== tgt[i] || bus.flush !== 1'b1) begin
                n_bad++; $display("FAIL bypass[%0d] got pc=%h f=%b exp %h 1", i, bus.newpc, bus.flush, tgt[i]);
            end
            step(); step();
        end
    endtask

    task automatic test_rst_in_flush();
        clear_inputs();
        bus.fetch_ack = 1'b0;
        mem_valid_i = 1; f_break_i = 1;
        step(); clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL rstf_pre got %b exp 1", bus.flush); end
        rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.newpc !== 32'h0) begin
            n_bad++; $display("FAIL rstf_post got f=%b r=%b pc=%h exp 0 0 0", bus.flush, bus.redirect_valid, bus.newpc);
        end
        rst = 1'b0;
        bus.fetch_ack = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_interrupt();
        test_stall_ades();
        test_eret_backpressure();
        test_epc_bypass();
        test_rst_in_flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL queue_left got %0d exp 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
